// File: rtl/heaa_sched_pkg.sv
// Shared types and constants for the HEAA round-robin scheduler slice.
//   state_t     : output-slot state (IDLE = empty, FULL = result held)
//   HEAA_W      : adder operand width
//   HEAA_SUM_W  : adder result width (operand width + carry-out)
//   ERR_CNT_W   : width of the optional approximation-error counter
package heaa_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam int unsigned HEAA_W     = 12;
  localparam int unsigned HEAA_SUM_W = 13;
  localparam int unsigned ERR_CNT_W  = 16;

endpackage

// File: rtl/heaa_12b9inacc.sv
// 12-bit HEAA approximate adder with a 9-bit inaccurate lower part.
//   a_i, b_i : 12-bit operands
//   sum_o    : 13-bit approximate sum
// Bits [7:0] are OR-ed with no carry, bit 8 is a half adder whose generate
// feeds the exact upper 3-bit adder, which also produces the carry-out.
module heaa_12b9inacc
  import heaa_sched_pkg::*;
(
  input  logic [HEAA_W-1:0]     a_i,
  input  logic [HEAA_W-1:0]     b_i,
  output logic [HEAA_SUM_W-1:0] sum_o
);

  logic       g8;
  logic [3:0] hi;

  assign g8 = a_i[8] & b_i[8];
  assign hi = {1'b0, a_i[11:9]} + {1'b0, b_i[11:9]} + {3'b000, g8};

  assign sum_o = {hi, a_i[8] ^ b_i[8], a_i[7:0] | b_i[7:0]};

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority selector (purely combinational).
//   req_valid_i : per-requester request vector
//   ptr_i       : index holding highest priority this cycle
//   gnt_o       : one-hot grant (zero when nothing is requested)
//   found_o     : at least one request was granted
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            found_o
);

  // Requester i has priority distance (i - ptr) mod NREQ; the smallest
  // distance among valid requesters wins. Indices stay loop constants.
  always_comb begin
    gnt_o   = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found_o && req_valid_i[i] &&
            ((i + NREQ - 32'(ptr_i)) % NREQ) == k) begin
          gnt_o[i] = 1'b1;
          found_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/heaa_rr_sched.sv
// Round-robin scheduler sharing one HEAA approximate adder among NREQ
// requesters, with a single registered, tagged result slot.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/ready   : per-requester operand handshake (ready one-hot/zero)
//   req_a, req_b      : packed operands, requester i at [i*W +: W]
//   resp_valid/ready  : result handshake with backpressure
//   resp_sum, resp_id : approximate sum and owning requester index
// Optional (HEAA_ERR_STATS_EN): err_clr input, err_cnt output counting
// accepts whose approximate sum differs from the exact sum (saturating).
module heaa_rr_sched
  import heaa_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned W    = HEAA_W,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [W:0]      resp_sum,
  output logic [IDW-1:0]  resp_id
`ifdef HEAA_ERR_STATS_EN
  ,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic           resp_valid_q;
  logic [W:0]     sum_q;
  logic [IDW-1:0] id_q;

  logic            slot_free;
  logic            found;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr_d;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W:0]      sum_apx;

  // Draining and refilling in the same cycle keeps one result per cycle.
  assign slot_free = (state_q == IDLE) | (resp_valid_q & resp_ready);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .found_o     (found)
  );

  assign accept    = rst_n & slot_free & found;
  assign req_ready = accept ? gnt : '0;

  always_comb begin
    gnt_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDW'(i);
        a_sel   = req_a[i*W +: W];
        b_sel   = req_b[i*W +: W];
      end
    end
  end

  assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  heaa_12b9inacc u_add (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .sum_o (sum_apx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      sum_q        <= '0;
      id_q         <= '0;
    end else if (accept) begin
      state_q      <= FULL;
      ptr_q        <= ptr_d;
      resp_valid_q <= 1'b1;
      sum_q        <= sum_apx;
      id_q         <= gnt_idx;
    end else if (slot_free) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_sum   = sum_q;
  assign resp_id    = id_q;

`ifdef HEAA_ERR_STATS_EN
  logic [W:0]           sum_exact;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign sum_exact = {1'b0, a_sel} + {1'b0, b_sel};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (accept && (sum_exact != sum_apx) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_heaa_rr_sched.sv
module tb_heaa_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [W:0]        resp_sum;
  logic [IDW-1:0]    resp_id;
`ifdef HEAA_ERR_STATS_EN
  logic              err_clr = 1'b0;
  logic [15:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  heaa_rr_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id)
`ifdef HEAA_ERR_STATS_EN
    ,
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one output slot, a priority pointer, arithmetic adder.
  bit m_known = 0;
  bit m_full  = 0;
  int m_ptr   = 0;
  int m_sum   = 0;
  int m_id    = 0;
  int m_err   = 0;

  function automatic int approx_sum(input int a, input int b);
    int lo, b8, hi;
    lo = (a & 'hFF) | (b & 'hFF);
    b8 = ((a >> 8) ^ (b >> 8)) & 1;
    hi = ((a >> 9) & 7) + ((b >> 9) & 7) + ((a >> 8) & (b >> 8) & 1);
    return lo + (b8 << 8) + (hi << 9);
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Checks the current cycle against the model at the falling edge, then
  // advances the model across the rising edge.
  task automatic step();
    int g;
    bit sf;
    int a, b, s;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    if (m_known) begin
      chk_eq("resp_valid", 32'(resp_valid), 32'(m_full));
      if (m_full) begin
        chk_eq("resp_sum", 32'(resp_sum), 32'(m_sum));
        chk_eq("resp_id", 32'(resp_id), 32'(m_id));
      end
`ifdef HEAA_ERR_STATS_EN
      chk_eq("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
    end
    g  = -1;
    sf = !m_full || resp_ready;
    if (rst_n && sf) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    chk_eq("req_ready", 32'(req_ready), 32'(exp_rdy));

    if (!rst_n) begin
      m_full = 0; m_ptr = 0; m_sum = 0; m_id = 0; m_err = 0; m_known = 1;
    end else begin
      if (g >= 0) begin
        a = int'(req_a[g*W +: W]);
        b = int'(req_b[g*W +: W]);
        s = approx_sum(a, b);
`ifdef HEAA_ERR_STATS_EN
        if (err_clr) m_err = 0;
        else if (s != a + b && m_err < 65535) m_err++;
`endif
        m_sum = s; m_id = g; m_full = 1; m_ptr = (g + 1) % NREQ;
      end else begin
`ifdef HEAA_ERR_STATS_EN
        if (err_clr) m_err = 0;
`endif
        if (sf) m_full = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int ids[5];

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 4095), $urandom_range(0, 4095));

    // Reset held with every requester asking.
    repeat (3) step();
    chk_eq("rst_valid", 32'(resp_valid), 32'd0);
    chk_eq("rst_sum", 32'(resp_sum), 32'd0);
    chk_eq("rst_id", 32'(resp_id), 32'd0);

    // Release: first grant to requester 0, then strict rotation.
    rst_n = 1'b1;
    #1;
    chk_eq("first_grant", 32'(req_ready), 32'h1);
    for (int n = 0; n < 5; n++) begin
      step();
      ids[n] = int'(resp_id);
      chk_eq("rr_valid", 32'(resp_valid), 32'd1);
    end
    for (int n = 0; n < 5; n++) chk_eq("rr_id", 32'(ids[n]), 32'(n % NREQ));

    // Single request and carry path.
    req_valid = 4'b0001;
    set_op(0, 'h0FF, 'h001); step();
    chk_eq("single_sum", 32'(resp_sum), 32'h0FF);
    chk_eq("single_id", 32'(resp_id), 32'd0);
    set_op(0, 'h100, 'h100); step();
    chk_eq("carry8_sum", 32'(resp_sum), 32'h200);
    set_op(0, 'hFFF, 'h001); step();
    chk_eq("carry_out_sum", 32'(resp_sum), 32'hFFF);

    // Backpressure: result holds, nobody is accepted.
    req_valid  = '1;
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 4095), $urandom_range(0, 4095));
    repeat (5) begin
      step();
      chk_eq("bp_sum", 32'(resp_sum), 32'hFFF);
      chk_eq("bp_id", 32'(resp_id), 32'd0);
      chk_eq("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk_eq("drain_grant", 32'(req_ready), 32'h2);
    step();
    chk_eq("drain_id", 32'(resp_id), 32'd1);

    // Drain only.
    req_valid = '0;
    step();
    chk_eq("drain_only_valid", 32'(resp_valid), 32'd0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      req_valid  = NREQ'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(0, 4095), $urandom_range(0, 4095));
`ifdef HEAA_ERR_STATS_EN
      err_clr = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
    rst_n = 1'b1;

`ifdef HEAA_ERR_STATS_EN
    // Saturation, then clear winning over a mismatching accept.
    err_clr    = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    set_op(0, 'h0FF, 'h001);
    repeat (70000) step();
    chk_eq("err_sat", 32'(err_cnt), 32'hFFFF);
    err_clr = 1'b1;
    step();
    chk_eq("err_clr", 32'(err_cnt), 32'd0);
    err_clr = 1'b0;
    step();
    chk_eq("err_after_clr", 32'(err_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heaa_rr_sched.md
Name: heaa_rr_sched

Overview:
- Round-robin scheduler that shares one 12-bit HEAA approximate adder (heaa_12b9inacc) among NREQ requesters.
- Each requester presents operands over a valid/ready handshake.
- The scheduler grants one requester per cycle, registers its operands, and returns a tagged 13-bit result over a valid/ready response channel with backpressure.
- It sits between the approximate-arithmetic clients and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 12, operand width; fixed at 12 to match the adder instance.
- IDW, $clog2(NREQ), requester-ID width (derived, do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B; same packing as req_a.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_sum  out  W+1  approximate sum.
- resp_id  out  IDW  index of the requester that owns resp_sum.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - resp_valid=0, resp_sum=0, resp_id=0.
  - Round-robin pointer = 0; FSM = IDLE.
  - req_ready=0 while rst_n=0.
- Adder function (combinational, inside the sub-module):
  - sum[7:0] = a[7:0] | b[7:0].
  - sum[8] = a[8] ^ b[8]; g8 = a[8] & b[8].
  - sum[12:9] = a[11:9] + b[11:9] + g8, 4-bit result including carry-out.
- FSM states:
  - IDLE: output slot empty.
  - FULL: result held, waiting for resp_ready.
- Slot-free condition: slot_free = (state==IDLE) | (resp_valid & resp_ready). Drain and refill in the same cycle is allowed, giving full throughput of one result per cycle.
- Grant:
  - When slot_free, grant the first requester with req_valid=1, searching from pointer upward with wrap-around.
  - req_ready is asserted combinationally for the granted index only.
  - req_ready depends on req_valid and state; never on req_a or req_b.
- Accept (req_valid[i] & req_ready[i] at edge N):
  - Operands of requester i pass through the adder.
  - resp_sum, resp_id=i and resp_valid=1 are registered at edge N, so the result is visible in cycle N+1. Latency is 1.
  - Pointer becomes (i+1) mod NREQ; state becomes FULL.
- Backpressure:
  - While FULL and resp_ready=0: resp_* hold stable, all req_ready=0, pointer holds.
- Drain only (resp_ready=1, no req_valid): resp_valid=0 next cycle; state becomes IDLE.
- No valid requests: pointer unchanged, no grant.
- Fairness: a continuously requesting client is granted within NREQ accepts.
- Reset mid-operation: any pending result is discarded; the reset values above apply on the next cycle.

Optional Feature:
- Macro: HEAA_ERR_STATS_EN.
- With the macro defined:
  - Adds output port err_cnt (16 bits) and input port err_clr (1 bit).
  - err_cnt counts accepts where the approximate sum != a+b (exact 13-bit sum).
  - err_cnt saturates at 16'hFFFF and resets to 0.
  - err_clr=1 zeroes err_cnt on the next edge; clear wins over a same-cycle increment.
- Without the macro: neither port exists, and no exact adder or counter logic is present.

Decomposition:
- Package heaa_sched_pkg holds:
  - typedef state_t {IDLE, FULL}.
  - Constants HEAA_W=12 and HEAA_SUM_W=13.
  - Constant ERR_CNT_W=16.
- Sub-modules:
  - The datapath is one instance of the existing heaa_12b9inacc.
  - Round-robin priority selection is factored into sub-module rr_pick, a combinational function of (req_valid, pointer) that returns a grant one-hot plus a found flag.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> resp_valid=0 and req_ready=0 throughout; first grant goes to requester 0 on the first cycle after release.
- Single request: req0 a=0x0FF, b=0x001, resp_ready=1 -> next cycle resp_sum=0x0FF (exact sum 0x100), resp_id=0. With HEAA_ERR_STATS_EN, err_cnt=1.
- Carry path: a=0x100, b=0x100 -> resp_sum=0x200 (exact). Then a=0xFFF, b=0x001 -> resp_sum=0x0FFF (exact 0x1000).
- Round-robin: all 4 req_valid held high, resp_ready=1 -> resp_id sequence 0,1,2,3,0 on consecutive cycles, resp_valid continuously 1.
- Backpressure: resp_ready=0 for 5 cycles while results are pending -> resp_sum and resp_id stable, req_ready all 0. After resp_ready rises, the next grant comes from pointer order in the same cycle as the drain.
- Error stats: 70000 mismatching accepts -> err_cnt=0xFFFF saturated. Pulse err_clr together with a mismatching accept -> err_cnt=0.
